mux_5to1_st: RTL and testbench
==============================

Name:
mux_5to1_st

Overview:
- 5:1 multiplexer built structurally from a tree of 2:1 mux cells.
- Provides a combinational output and a registered copy of that output for timing-closed consumers.
- Flags select codes outside the valid range 0–4.
- Sits in datapath select logic wherever one of five sources is steered onto a single line.

Parameters:
- WIDTH, 1, bit width of each data input and of the output. Default 1 gives a 5-bit input bus I[4:0].

Ports:
- clk  input  1  rising-edge clock for registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- I  input  5*WIDTH  packed data inputs. Input k occupies I[k*WIDTH +: WIDTH], k = 0..4.
- S  input  3  select code.
- Y  output  WIDTH  combinational mux output.
- sel_err  output  1  combinational flag: S is out of range (S >= 5).
- Y_q  output  WIDTH  Y registered on clk.
- sel_err_q  output  1  sel_err registered on clk.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Combinational path: zero latency. Y settles within the same delta/time step as I or S changes, with no clock involvement.
- Select mapping:
  - S=0 → input 0; S=1 → input 1; S=2 → input 2; S=3 → input 3; S=4 → input 4.
  - S=5, 6, 7 → Y all zeros, sel_err=1.
  - S=0..4 → sel_err=0.
- Structure:
  - Level 1: two 2:1 cells on S[0]: (in0, in1) → a; (in2, in3) → b.
  - Level 2: one 2:1 cell on S[1]: (a, b) → c.
  - Level 3: one 2:1 cell on S[2]: (c, in4) → d.
  - Zero gate: Y = d AND NOT(S[2] AND (S[1] OR S[0])), replicated across WIDTH.
  - The 2:1 cell is a separate reusable submodule. Out = sel ? in1 : in0, WIDTH-parameterised.
- Registered path:
  - On rising clk: Y_q <= Y, sel_err_q <= sel_err. Latency is one cycle.
  - rst_n low → Y_q = 0 and sel_err_q = 0 immediately, independent of clk. Both are held at 0 while rst_n is low.
  - First capture occurs on the first rising clk after rst_n deasserts.
  - Reset does not affect Y or sel_err. The combinational path stays live during reset.
- Unknowns: if S contains X/Z, Y may be X. For fully known I and S, Y and sel_err are never X/Z.
- No internal state besides the two output registers. No handshake.

Test Plan:
- Combinational sweep, WIDTH=1: I=5'b10110, S=0..4, 10 time units each → Y = 0,1,1,0,1 respectively; sel_err=0 throughout.
- Out-of-range selects: I=5'b11111, S=5,6,7 → Y=0, sel_err=1 for each.
- Random check: 10 iterations with I=$random and S=$random%8. After 10 time units, compare Y against the reference model (I[S] for S<5, else 0) with case inequality. Any mismatch fails the test.
- Registered path: rst_n=0 → Y_q=0, sel_err_q=0. Release reset, drive I=5'b01000, S=3, clock once → Y_q=1. Drive S=6, clock once → Y_q=0, sel_err_q=1.
- Async reset mid-operation: with Y_q=1, assert rst_n=0 between clock edges → Y_q drops to 0 without a clock edge, while Y still reflects I[S].
- WIDTH=4 instance: I={4'hE,4'hD,4'hC,4'hB,4'hA}, S=0..4 → Y = A,B,C,D,E. S=7 → Y=4'h0.

Source files
------------

// File: rtl/mux_5to1_st.sv
// 5:1 mux built as a tree of 2:1 cells, with a
// registered copy of the output and select error.
module mux2_cell #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

module mux_5to1_st #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5*WIDTH-1:0] I,
  input  logic [2:0]         S,
  output logic [WIDTH-1:0]   Y,
  output logic               sel_err,
  output logic [WIDTH-1:0]   Y_q,
  output logic               sel_err_q
);

  logic [WIDTH-1:0] in0, in1, in2, in3, in4;
  logic [WIDTH-1:0] a, b, c, d;
  logic             zero;

  assign in0 = I[0*WIDTH +: WIDTH];
  assign in1 = I[1*WIDTH +: WIDTH];
  assign in2 = I[2*WIDTH +: WIDTH];
  assign in3 = I[3*WIDTH +: WIDTH];
  assign in4 = I[4*WIDTH +: WIDTH];

  mux2_cell #(.WIDTH(WIDTH)) u_l1a (
    .sel (S[0]),
    .in0 (in0),
    .in1 (in1),
    .y   (a)
  );

  mux2_cell #(.WIDTH(WIDTH)) u_l1b (
    .sel (S[0]),
    .in0 (in2),
    .in1 (in3),
    .y   (b)
  );

  mux2_cell #(.WIDTH(WIDTH)) u_l2 (
    .sel (S[1]),
    .in0 (a),
    .in1 (b),
    .y   (c)
  );

  mux2_cell #(.WIDTH(WIDTH)) u_l3 (
    .sel (S[2]),
    .in0 (c),
    .in1 (in4),
    .y   (d)
  );

  // codes 5..7 land on in4 via the tree; mask them off
  assign zero    = S[2] & (S[1] | S[0]);
  assign Y       = d & {WIDTH{~zero}};
  assign sel_err = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q       <= '0;
      sel_err_q <= 1'b0;
    end else begin
      Y_q       <= Y;
      sel_err_q <= sel_err;
    end
  end

endmodule

// File: tb/tb_mux_5to1_st.sv
// Bench for mux_5to1_st: vector tables, random
// model checks and registered/reset sequences.
module tb_mux_5to1_st;

  logic       clk;
  logic       rst_n;
  logic [4:0] i1;
  logic [2:0] s1;
  logic       y1, e1, yq1, eq1;

  logic [19:0] i4;
  logic [2:0]  s4;
  logic [3:0]  y4, yq4;
  logic        e4, eq4;

  int checks;
  int errors;

  mux_5to1_st #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .I         (i1),
    .S         (s1),
    .Y         (y1),
    .sel_err   (e1),
    .Y_q       (yq1),
    .sel_err_q (eq1)
  );

  mux_5to1_st #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .I         (i4),
    .S         (s4),
    .Y         (y4),
    .sel_err   (e4),
    .Y_q       (yq4),
    .sel_err_q (eq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [4:0] i;
    logic       y;
    logic       err;
  } vec1_t;

  typedef struct {
    logic [2:0] s;
    logic [3:0] y;
    logic       err;
  } vec4_t;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // reference: pick field s of a packed bus, zero if s>=5
  function automatic logic [3:0] ref_mux(
    input logic [19:0] bus, input int s, input int w);
    logic [19:0] sh;
    if (s >= 5) return 4'h0;
    sh = bus >> (s * w);
    return sh[3:0] & 4'((1 << w) - 1);
  endfunction

  vec1_t t1[8];
  vec4_t t4[6];

  initial begin
    logic [3:0] ey, ey4;
    logic       ee;
    checks = 0;
    errors = 0;

    t1[0] = '{3'd0, 5'b10110, 1'b0, 1'b0};
    t1[1] = '{3'd1, 5'b10110, 1'b1, 1'b0};
    t1[2] = '{3'd2, 5'b10110, 1'b1, 1'b0};
    t1[3] = '{3'd3, 5'b10110, 1'b0, 1'b0};
    t1[4] = '{3'd4, 5'b10110, 1'b1, 1'b0};
    t1[5] = '{3'd5, 5'b11111, 1'b0, 1'b1};
    t1[6] = '{3'd6, 5'b11111, 1'b0, 1'b1};
    t1[7] = '{3'd7, 5'b11111, 1'b0, 1'b1};

    t4[0] = '{3'd0, 4'hA, 1'b0};
    t4[1] = '{3'd1, 4'hB, 1'b0};
    t4[2] = '{3'd2, 4'hC, 1'b0};
    t4[3] = '{3'd3, 4'hD, 1'b0};
    t4[4] = '{3'd4, 4'hE, 1'b0};
    t4[5] = '{3'd7, 4'h0, 1'b1};

    rst_n = 1'b0;
    i1 = '0;
    s1 = '0;
    i4 = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    s4 = '0;
    #2;
    check("rst_yq", {31'b0, yq1}, 32'd0);
    check("rst_errq", {31'b0, eq1}, 32'd0);
    check("rst_yq4", {28'b0, yq4}, 32'd0);

    // combinational path while still in reset
    foreach (t1[k]) begin
      i1 = t1[k].i;
      s1 = t1[k].s;
      #10;
      check($sformatf("w1_y_s%0d", t1[k].s),
            {31'b0, y1}, {31'b0, t1[k].y});
      check($sformatf("w1_err_s%0d", t1[k].s),
            {31'b0, e1}, {31'b0, t1[k].err});
    end

    foreach (t4[k]) begin
      s4 = t4[k].s;
      #10;
      check($sformatf("w4_y_s%0d", t4[k].s),
            {28'b0, y4}, {28'b0, t4[k].y});
      check($sformatf("w4_err_s%0d", t4[k].s),
            {31'b0, e4}, {31'b0, t4[k].err});
    end
    check("rst_hold_yq", {31'b0, yq1}, 32'd0);

    for (int n = 0; n < 10; n++) begin
      i1 = 5'($urandom);
      s1 = 3'($urandom % 8);
      #10;
      ey = ref_mux({15'b0, i1}, int'(s1), 1);
      check("rand_w1_y", {31'b0, y1}, {31'b0, ey[0]});
      check("rand_w1_err", {31'b0, e1},
            {31'b0, (s1 >= 3'd5)});
    end

    // registered path
    @(negedge clk);
    rst_n = 1'b1;
    i1 = 5'b01000;
    s1 = 3'd3;
    @(posedge clk);
    #1;
    check("reg_yq_s3", {31'b0, yq1}, 32'd1);
    check("reg_errq_s3", {31'b0, eq1}, 32'd0);
    s1 = 3'd6;
    @(posedge clk);
    #1;
    check("reg_yq_s6", {31'b0, yq1}, 32'd0);
    check("reg_errq_s6", {31'b0, eq1}, 32'd1);

    // random registered path, both widths
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      i1 = 5'($urandom);
      s1 = 3'($urandom % 8);
      i4 = 20'($urandom);
      s4 = 3'($urandom % 8);
      ey  = ref_mux({15'b0, i1}, int'(s1), 1);
      ey4 = ref_mux(i4, int'(s4), 4);
      ee  = (s4 >= 3'd5);
      @(posedge clk);
      #1;
      check("rand_w1_yq", {31'b0, yq1}, {31'b0, ey[0]});
      check("rand_w4_yq", {28'b0, yq4}, {28'b0, ey4});
      check("rand_w4_errq", {31'b0, eq4}, {31'b0, ee});
      check("rand_w4_y", {28'b0, y4}, {28'b0, ey4});
    end

    // async reset between edges
    @(negedge clk);
    i1 = 5'b01000;
    s1 = 3'd3;
    @(posedge clk);
    #1;
    check("pre_async_yq", {31'b0, yq1}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_yq", {31'b0, yq1}, 32'd0);
    check("async_errq", {31'b0, eq1}, 32'd0);
    check("async_y_live", {31'b0, y1}, 32'd1);
    @(posedge clk);
    #1;
    check("async_hold_yq", {31'b0, yq1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
